// File: rtl/alu_operand_regfile.sv
// Operand supply and writeback for the execute ALU: decodes the issued MIPS word,
// drives bypassed rs/rt operands, captures the result into a one-entry writeback stage.
module alu_operand_regfile #(
   parameter int DATA_W  = 32,
   parameter int NREG    = 32,
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               instr_valid,
   input  logic [31:0]        instruction,
   input  logic [DATA_W-1:0]  alu_result,
   input  logic [2:0]         alu_flags,
   input  logic [DATA_W-1:0]  load_data,
   output logic [31:0]        alu_instr,
   output logic [DATA_W-1:0]  regA,
   output logic [DATA_W-1:0]  regB,
   output logic               wb_valid,
   output logic [4:0]         wb_addr,
   output logic [DATA_W-1:0]  wb_data,
   output logic               ovf_trap,
   output logic               illegal,
   output logic [COUNT_W-1:0] retired_count,
   input  logic [4:0]         dbg_addr,
   output logic [DATA_W-1:0]  dbg_data
);

   logic [DATA_W-1:0]  r_regs [NREG];
   logic               r_wb_valid;
   logic [4:0]         r_wb_addr;
   logic [DATA_W-1:0]  r_wb_data;
   logic               r_ovf_trap;
   logic               r_illegal;
   logic [COUNT_W-1:0] r_count;

   logic [5:0]         w_op;
   logic [5:0]         w_funct;
   logic [4:0]         w_rs;
   logic [4:0]         w_rt;
   logic [4:0]         w_rd;
   logic               w_legal;
   logic               w_ovf_op;
   logic               w_ovf;
   logic [4:0]         w_dest;
   logic [DATA_W-1:0]  w_data;
   logic               w_unused_flags;

   assign w_op    = instruction[31:26];
   assign w_rs    = instruction[25:21];
   assign w_rt    = instruction[20:16];
   assign w_rd    = instruction[15:11];
   assign w_funct = instruction[5:0];
   // Only the overflow flag matters here; zero/negative belong to branch logic.
   assign w_unused_flags = ^alu_flags[1:0];

   always_comb begin
      w_legal  = 1'b0;
      w_ovf_op = 1'b0;
      w_dest   = 5'd0;
      w_data   = alu_result;
      case (w_op)
         6'h00: begin
            case (w_funct)
               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
               6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
                  w_legal  = 1'b1;
                  w_dest   = w_rd;
                  w_ovf_op = (w_funct == 6'h20) || (w_funct == 6'h22);
               end
               default: ;
            endcase
         end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
            w_legal  = 1'b1;
            w_dest   = w_rt;
            w_ovf_op = (w_op == 6'h08);
         end
         6'h23: begin
            w_legal = 1'b1;
            w_dest  = w_rt;
            w_data  = load_data;
         end
         6'h04, 6'h05, 6'h2B: w_legal = 1'b1;
         default: ;
      endcase
   end

   assign w_ovf = alu_flags[2] & w_ovf_op;

   // Commit of the pending entry and capture of the next one share the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
         r_wb_valid <= 1'b0;
         r_wb_addr  <= 5'd0;
         r_wb_data  <= '0;
         r_ovf_trap <= 1'b0;
         r_illegal  <= 1'b0;
         r_count    <= '0;
      end else begin
         if (r_wb_valid) r_regs[r_wb_addr] <= r_wb_data;
         r_wb_valid <= instr_valid & w_legal & (w_dest != 5'd0) & ~w_ovf;
         r_ovf_trap <= instr_valid & w_legal & w_ovf;
         r_illegal  <= instr_valid & ~w_legal;
         if (instr_valid) begin
            r_wb_addr <= w_dest;
            r_wb_data <= w_data;
         end
         if (instr_valid & w_legal) r_count <= r_count + 1'b1;
      end
   end

   // Newest pending write shadows the array; r0 always reads zero.
   always_comb begin
      regA = '0;
      regB = '0;
      if (w_rs != 5'd0) regA = (r_wb_valid && r_wb_addr == w_rs) ? r_wb_data : r_regs[w_rs];
      if (w_rt != 5'd0) regB = (r_wb_valid && r_wb_addr == w_rt) ? r_wb_data : r_regs[w_rt];
   end

   assign alu_instr     = instruction;
   assign dbg_data      = (dbg_addr == 5'd0) ? '0 : r_regs[dbg_addr];
   assign wb_valid      = r_wb_valid;
   assign wb_addr       = r_wb_addr;
   assign wb_data       = r_wb_data;
   assign ovf_trap      = r_ovf_trap;
   assign illegal       = r_illegal;
   assign retired_count = r_count;

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Directed bench for alu_operand_regfile: decode, bypass, commit, traps and counter.
module tb_alu_operand_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic [31:0] instruction;
   logic [31:0] alu_result;
   logic [2:0]  alu_flags;
   logic [31:0] load_data;
   logic [31:0] alu_instr;
   logic [31:0] regA;
   logic [31:0] regB;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ovf_trap;
   logic        illegal;
   logic [31:0] retired_count;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   int n_checks = 0;
   int n_fails  = 0;

   alu_operand_regfile dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
      .alu_result(alu_result), .alu_flags(alu_flags), .load_data(load_data),
      .alu_instr(alu_instr), .regA(regA), .regB(regB), .wb_valid(wb_valid),
      .wb_addr(wb_addr), .wb_data(wb_data), .ovf_trap(ovf_trap), .illegal(illegal),
      .retired_count(retired_count), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] ins, input logic [31:0] res,
                        input logic [2:0] flg, input logic [31:0] ld);
      instr_valid = 1'b1;
      instruction = ins;
      alu_result  = res;
      alu_flags   = flg;
      load_data   = ld;
      #1;
   endtask

   task automatic idle();
      instr_valid = 1'b0;
      alu_flags   = 3'b000;
      #1;
   endtask

   task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
      dbg_addr = a;
      #1;
      check(tag, dbg_data, exp);
   endtask

   initial begin
      reset = 1'b1; instr_valid = 1'b0; instruction = 32'h0;
      alu_result = 32'h0; alu_flags = 3'b000; load_data = 32'h0; dbg_addr = 5'd0;
      tick(); tick();
      reset = 1'b0;
      #1;
      for (int i = 0; i < 32; i++) peek("reset_reg", 5'(i), 32'h0);
      check("reset_count", retired_count, 32'd0);
      check("reset_wbv", {31'd0, wb_valid}, 32'd0);
      check("reset_trap", {30'd0, ovf_trap, illegal}, 32'd0);

      // addi r1,r0,5
      issue(32'h20010005, 32'd5, 3'b000, 32'h0);
      check("alu_instr", alu_instr, 32'h20010005);
      tick(); idle();
      check("addi_wbv", {31'd0, wb_valid}, 32'd1);
      check("addi_addr", {27'd0, wb_addr}, 32'd1);
      check("addi_data", wb_data, 32'd5);
      check("addi_count", retired_count, 32'd1);
      peek("addi_precommit", 5'd1, 32'd0);
      tick();
      peek("addi_commit", 5'd1, 32'd5);
      check("addi_wbv_clr", {31'd0, wb_valid}, 32'd0);

      // addi r1,r0,7 then add r2,r1,r1 reading r1 through the bypass
      issue(32'h20010007, 32'd7, 3'b000, 32'h0);
      tick();
      issue(32'h00211020, 32'd14, 3'b000, 32'h0);
      check("byp_regA", regA, 32'd7);
      check("byp_regB", regB, 32'd7);
      peek("byp_array_old", 5'd1, 32'd5);
      tick(); idle();
      check("add_addr", {27'd0, wb_addr}, 32'd2);
      check("add_data", wb_data, 32'd14);
      tick();
      peek("add_commit_r2", 5'd2, 32'd14);
      peek("add_commit_r1", 5'd1, 32'd7);
      check("add_count", retired_count, 32'd3);

      // add overflow: trap, no write, retired
      issue(32'h00211020, 32'h12345678, 3'b100, 32'h0);
      tick(); idle();
      check("ovf_trap", {31'd0, ovf_trap}, 32'd1);
      check("ovf_wbv", {31'd0, wb_valid}, 32'd0);
      check("ovf_count", retired_count, 32'd4);
      tick();
      check("ovf_pulse", {31'd0, ovf_trap}, 32'd0);
      peek("ovf_r2", 5'd2, 32'd14);

      // addu r4,r1,r1 ignores the overflow flag
      issue(32'h00212021, 32'd9, 3'b100, 32'h0);
      tick(); idle();
      check("addu_trap", {31'd0, ovf_trap}, 32'd0);
      check("addu_wbv", {31'd0, wb_valid}, 32'd1);
      tick();
      peek("addu_r4", 5'd4, 32'd9);

      // lw r3 takes load_data
      issue(32'h8C030004, 32'd4, 3'b000, 32'hDEADBEEF);
      tick(); idle();
      check("lw_data", wb_data, 32'hDEADBEEF);
      check("lw_addr", {27'd0, wb_addr}, 32'd3);
      tick();
      peek("lw_r3", 5'd3, 32'hDEADBEEF);

      // sw and beq retire without writing
      issue(32'hAC030008, 32'd8, 3'b000, 32'h0);
      tick();
      issue(32'h10220003, 32'd0, 3'b001, 32'h0);
      check("sw_wbv", {31'd0, wb_valid}, 32'd0);
      tick(); idle();
      check("beq_wbv", {31'd0, wb_valid}, 32'd0);
      check("beq_illegal", {31'd0, illegal}, 32'd0);
      check("sw_beq_count", retired_count, 32'd8);

      // illegal opcode 3F and illegal funct 01
      issue(32'hFC000000, 32'd1, 3'b000, 32'h0);
      tick(); idle();
      check("ill_op", {31'd0, illegal}, 32'd1);
      check("ill_op_wbv", {31'd0, wb_valid}, 32'd0);
      tick();
      check("ill_pulse", {31'd0, illegal}, 32'd0);
      issue(32'h00000001, 32'd1, 3'b000, 32'h0);
      tick(); idle();
      check("ill_funct", {31'd0, illegal}, 32'd1);
      check("ill_count", retired_count, 32'd8);

      // addi r0,r0,9: retired, never visible
      issue(32'h20000009, 32'd9, 3'b000, 32'h0);
      tick(); idle();
      check("r0_wbv", {31'd0, wb_valid}, 32'd0);
      tick();
      peek("r0_read", 5'd0, 32'd0);
      check("r0_count", retired_count, 32'd9);

      // two writes to r5 back-to-back; newest wins on bypass
      issue(32'h20050001, 32'd1, 3'b000, 32'h0);
      tick();
      issue(32'h20050002, 32'd2, 3'b000, 32'h0);
      tick();
      issue(32'h00A53020, 32'd4, 3'b000, 32'h0);
      check("newest_regA", regA, 32'd2);
      check("newest_regB", regB, 32'd2);
      tick(); idle();
      tick();
      peek("newest_r5", 5'd5, 32'd2);
      peek("newest_r6", 5'd6, 32'd4);
      check("newest_count", retired_count, 32'd12);

      // reset with a pending write drops it
      issue(32'h20070077, 32'h77, 3'b000, 32'h0);
      tick(); idle();
      check("rst_pending", {31'd0, wb_valid}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("rst_wbv", {31'd0, wb_valid}, 32'd0);
      check("rst_count", retired_count, 32'd0);
      peek("rst_r7", 5'd7, 32'd0);
      peek("rst_r5", 5'd5, 32'd0);
      tick();
      peek("rst_r7_later", 5'd7, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
